mem_responder: RTL and testbench

Responder end of the NockPU memory request interface that execution blocks (increment, traversal, etc.) drive through the memory mux. It accepts one request per `mem_execute` rising edge, performs a read, write or heap allocation on an internal single-port synchronous noun RAM, and returns a one-cycle `mem_ready` with read data. It also owns the free-cell pointer exported as `free_addr`.

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Responder side of the NockPU memory request interface: serves GET/SET/ALLOC
// requests against a single-port synchronous noun RAM and owns the heap free pointer.
module mem_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int FREE_BASE = 0,
  // ADDR_W must be wide enough to hold MEM_DEPTH itself so a full heap is visible on free_addr
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_execute,
  input  logic [1:0]        mem_func,
  input  logic [ADDR_W-1:0] address1,
  input  logic [ADDR_W-1:0] address2,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_ready,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [ADDR_W-1:0] free_addr,
  output logic              mem_error,
  output logic              heap_full
);

  localparam int              IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] BASE_L  = (ADDR_W+1)'(FREE_BASE);
  localparam logic [1:0]      F_GET   = 2'd0;
  localparam logic [1:0]      F_SET   = 2'd1;
  localparam logic [1:0]      F_ALLOC = 2'd2;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, RESP} state_t;

  state_t              state, state_nxt;
  logic                exec_ff;
  logic                start;
  logic                req_err;
  logic [1:0]          func_q;
  logic [IDX_W-1:0]    a1_q, a2_q;
  logic [DATA_W-1:0]   wd_q;
  logic                err_q;
  logic [ADDR_W:0]     free_q;
  logic [DATA_W-1:0]   mem [0:MEM_DEPTH-1];
  logic [DATA_W-1:0]   ram_q;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] p);
    return (p >= DEPTH_L) ? DEPTH_L : p + 1'b1;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // mem_ready gating keeps the response cycle closed to new requests
  assign start     = mem_execute && !exec_ff && !mem_ready && (state == IDLE);
  assign heap_full = (free_q == DEPTH_L);
  assign free_addr = free_q[ADDR_W-1:0];

  always_comb begin
    req_err = 1'b0;
    case (mem_func)
      F_GET:   req_err = !in_range(address1) || !in_range(address2);
      F_SET:   req_err = !in_range(address1);
      F_ALLOC: req_err = heap_full;
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_err)                state_nxt = RESP;
          else if (mem_func == F_GET) state_nxt = RD1;
          else                        state_nxt = WR;
        end
      end
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      exec_ff    <= 1'b0;
      mem_ready  <= 1'b0;
      mem_error  <= 1'b0;
      read_data1 <= '0;
      read_data2 <= '0;
      free_q     <= BASE_L;
    end else begin
      state     <= state_nxt;
      exec_ff   <= mem_execute;
      mem_ready <= (state == RESP);
      mem_error <= (state == RESP) && err_q;
      if (state == RD2)
        read_data1 <= ram_q;
      if ((state == RESP) && (func_q == F_GET) && !err_q)
        read_data2 <= ram_q;
      if ((state == WR) && (func_q == F_ALLOC)) begin
        read_data1 <= DATA_W'(free_q);
        read_data2 <= '0;
        free_q     <= sat_inc(free_q);
      end
    end
  end

  // request fields are captured once at acceptance and ignored afterwards
  always_ff @(posedge clk) begin
    if (start) begin
      func_q <= mem_func;
      a1_q   <= address1[IDX_W-1:0];
      a2_q   <= address2[IDX_W-1:0];
      wd_q   <= write_data;
      err_q  <= req_err;
    end
  end

  // one RAM access per cycle; a reset on the WR edge suppresses the write
  always_ff @(posedge clk) begin
    if (state == RD1)
      ram_q <= mem[a1_q];
    else if (state == RD2)
      ram_q <= mem[a2_q];
    if ((state == WR) && !rst) begin
      if (func_q == F_ALLOC) mem[free_q[IDX_W-1:0]] <= wd_q;
      else                   mem[a1_q]              <= wd_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses, a
// forked monitor pops and compares them whenever mem_ready is presented.
module tb_mem_responder;

  localparam int DEPTH = 16;
  localparam int BASE  = 14;
  localparam int AW    = 6;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_execute;
  logic [1:0]    mem_func;
  logic [AW-1:0] address1, address2;
  logic [DW-1:0] write_data;
  logic          mem_ready;
  logic [DW-1:0] read_data1, read_data2;
  logic [AW-1:0] free_addr;
  logic          mem_error;
  logic          heap_full;

  mem_responder #(.MEM_DEPTH(DEPTH), .FREE_BASE(BASE), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .mem_execute(mem_execute), .mem_func(mem_func),
    .address1(address1), .address2(address2), .write_data(write_data),
    .mem_ready(mem_ready), .read_data1(read_data1), .read_data2(read_data2),
    .free_addr(free_addr), .mem_error(mem_error), .heap_full(heap_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          err;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [AW-1:0] free;
    logic          hf;
  } exp_t;

  exp_t          q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] m_mem [0:DEPTH-1];
  logic [DW-1:0] m_rd1 = '0;
  logic [DW-1:0] m_rd2 = '0;
  int            m_free = BASE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model the request at the drive negedge and queue the response it must produce.
  task automatic push_expect(input logic [1:0] f, input int a1, input int a2, input logic [DW-1:0] wd);
    exp_t e;
    logic err;
    int   n;
    case (f)
      2'd0:    err = (a1 >= DEPTH) || (a2 >= DEPTH);
      2'd1:    err = (a1 >= DEPTH);
      2'd2:    err = (m_free >= DEPTH);
      default: err = 1'b1;
    endcase
    n = err ? 1 : ((f == 2'd0) ? 3 : 2);
    if (!err) begin
      case (f)
        2'd0: begin m_rd1 = m_mem[a1]; m_rd2 = m_mem[a2]; end
        2'd1: m_mem[a1] = wd;
        default: begin
          m_mem[m_free] = wd;
          m_rd1 = DW'(m_free);
          m_rd2 = '0;
          m_free++;
        end
      endcase
    end
    e.cyc  = cyc + 1 + n;
    e.err  = err;
    e.rd1  = m_rd1;
    e.rd2  = m_rd2;
    e.free = AW'(m_free);
    e.hf   = (m_free == DEPTH);
    q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] f, input int a1, input int a2, input logic [DW-1:0] wd);
    mem_func   = f;
    address1   = AW'(a1);
    address2   = AW'(a2);
    write_data = wd;
  endtask

  task automatic scramble();
    mem_func   = 2'($urandom);
    address1   = AW'($urandom);
    address2   = AW'($urandom);
    write_data = DW'($urandom);
  endtask

  task automatic issue(input logic [1:0] f, input int a1, input int a2, input logic [DW-1:0] wd);
    @(negedge clk);
    push_expect(f, a1, a2, wd);
    drive(f, a1, a2, wd);
    mem_execute = 1'b1;
    @(negedge clk);
    mem_execute = 1'b0;
    scramble();
    repeat (6) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("ready_cycle", cyc, e.cyc);
          chk("mem_error", {31'd0, mem_error}, {31'd0, e.err});
          chk("read_data1", {16'd0, read_data1}, {16'd0, e.rd1});
          chk("read_data2", {16'd0, read_data2}, {16'd0, e.rd2});
          chk("free_addr", {26'd0, free_addr}, {26'd0, e.free});
          chk("heap_full", {31'd0, heap_full}, {31'd0, e.hf});
        end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "_mem_error"}, {31'd0, mem_error}, 32'd0);
    chk({tag, "_read_data1"}, {16'd0, read_data1}, 32'd0);
    chk({tag, "_read_data2"}, {16'd0, read_data2}, 32'd0);
    chk({tag, "_free_addr"}, {26'd0, free_addr}, BASE);
    chk({tag, "_heap_full"}, {31'd0, heap_full}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    mem_execute = 1'b0;
    drive(2'd0, 0, 0, '0);
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    issue(2'd1, 5, 0, 16'h0ABC);
    issue(2'd1, 7, 0, 16'h0123);
    issue(2'd0, 5, 7, '0);

    // mem_execute held high for six cycles across a SET: a single response
    @(negedge clk);
    push_expect(2'd1, 3, 0, 16'h0055);
    drive(2'd1, 3, 0, 16'h0055);
    mem_execute = 1'b1;
    repeat (6) @(negedge clk);
    mem_execute = 1'b0;
    repeat (6) @(negedge clk);

    // second rising edge while a GET is busy carries a SET that must be dropped
    @(negedge clk);
    push_expect(2'd0, 5, 7, '0);
    drive(2'd0, 5, 7, '0);
    mem_execute = 1'b1;
    @(negedge clk);
    mem_execute = 1'b0;
    drive(2'd1, 3, 0, 16'h0FFF);
    @(negedge clk);
    mem_execute = 1'b1;
    @(negedge clk);
    mem_execute = 1'b0;
    repeat (8) @(negedge clk);
    issue(2'd0, 3, 3, '0);

    // rejected requests: out-of-range address2, reserved op, out-of-range address1
    issue(2'd0, 5, DEPTH, '0);
    issue(2'd3, 0, 0, 16'h1111);
    issue(2'd0, DEPTH, 0, '0);

    // heap fills after two allocations from FREE_BASE = DEPTH-2
    issue(2'd2, 0, 0, 16'h00A1);
    issue(2'd2, 0, 0, 16'h00A2);
    issue(2'd2, 0, 0, 16'h00A3);
    issue(2'd0, 14, 15, '0);

    issue(2'd1, 9, 0, 16'h0777);

    // reset on the WR edge of a SET to 9: no response, no write
    @(negedge clk);
    drive(2'd1, 9, 0, 16'h0999);
    mem_execute = 1'b1;
    @(negedge clk);
    mem_execute = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    rst = 1'b0;
    m_rd1  = '0;
    m_rd2  = '0;
    m_free = BASE;
    repeat (8) @(negedge clk);
    issue(2'd0, 9, 9, '0);

    // reset coinciding with a request edge: request lost
    @(negedge clk);
    drive(2'd1, 9, 0, 16'h0BAD);
    mem_execute = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_execute = 1'b0;
    m_rd1  = '0;
    m_rd2  = '0;
    m_free = BASE;
    repeat (8) @(negedge clk);
    issue(2'd0, 9, 5, '0);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
